// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic sequencer: phase codes, light codes and
// the mapping from a phase to the dwell parameter that times it.
package traffic_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } phase_t;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [1:0] {
        DurGreen,
        DurYellow,
        DurAllRed
    } dur_class_t;

    function automatic dur_class_t phase_dur(input phase_t p);
        dur_class_t r;
        case (p)
            S0, S4:         r = DurGreen;
            S2, S6:         r = DurAllRed;
            default:        r = DurYellow;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, never restarted by
// the phase logic so phase changes stay aligned to the tick grid.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/traffic_sequencer.sv
// Two-road traffic phase sequencer: synchronizes the road sensors, times each phase
// in ticks and steps the phase code S0..S7 in a fixed ring.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned T_MIN_GREEN = 5,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ta,
    input  logic       tb,
    output logic [2:0] s,
    output logic       state_change
);

    localparam int unsigned DMAX_GY = (T_MIN_GREEN > T_YELLOW) ? T_MIN_GREEN : T_YELLOW;
    localparam int unsigned DMAX    = (DMAX_GY > T_ALLRED) ? DMAX_GY : T_ALLRED;
    localparam int unsigned DW      = $clog2(DMAX + 1);

    logic          w_tick;
    logic [1:0]    r_ta_sync;
    logic [1:0]    r_tb_sync;
    phase_t        r_s;
    logic          r_state_change;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_last;
    logic          w_demand;
    logic          w_advance;
    phase_t        w_next;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ta_sync <= '0;
            r_tb_sync <= '0;
        end else begin
            r_ta_sync <= {r_ta_sync[0], ta};
            r_tb_sync <= {r_tb_sync[0], tb};
        end
    end

    always_comb begin
        w_last = '0;
        unique case (phase_dur(r_s))
            DurGreen:  w_last = DW'(T_MIN_GREEN - 1);
            DurYellow: w_last = DW'(T_YELLOW - 1);
            default:   w_last = DW'(T_ALLRED - 1);
        endcase
    end

    // Only green phases listen to the sensors; demand holds green past its minimum.
    always_comb begin
        w_demand = 1'b0;
        if (r_s == S0) begin
            w_demand = r_ta_sync[1];
        end else if (r_s == S4) begin
            w_demand = r_tb_sync[1];
        end
    end

    assign w_advance = w_tick && (r_dwell >= w_last) && !w_demand;

    always_comb begin
        w_next = S0;
        case (r_s)
            S0:      w_next = S1;
            S1:      w_next = S2;
            S2:      w_next = S3;
            S3:      w_next = S4;
            S4:      w_next = S5;
            S5:      w_next = S6;
            S6:      w_next = S7;
            S7:      w_next = S0;
            default: w_next = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s            <= S0;
            r_state_change <= 1'b0;
            r_dwell        <= '0;
        end else begin
            r_state_change <= w_advance;
            if (w_advance) begin
                r_s     <= w_next;
                r_dwell <= '0;
            end else if (w_tick && (r_dwell < w_last)) begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    assign s            = r_s;
    assign state_change = r_state_change;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer with TICK_DIV=4; cycle n is the sample taken
// just after the n-th rising edge following reset release.
module tb_traffic_sequencer;

    logic       clk;
    logic       reset;
    logic       ta;
    logic       tb;
    logic [2:0] s;
    logic       state_change;

    int checks;
    int errors;

    traffic_sequencer #(
        .TICK_DIV    (4),
        .T_MIN_GREEN (5),
        .T_YELLOW    (3),
        .T_ALLRED    (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ta           (ta),
        .tb           (tb),
        .s            (s),
        .state_change (state_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running sequence with no demand: phase boundaries at 20,32,36,48,68,80,84,96.
    function automatic logic [2:0] exp_phase(input int n);
        int m;
        m = n % 96;
        if (m < 20) return 3'd0;
        if (m < 32) return 3'd1;
        if (m < 36) return 3'd2;
        if (m < 48) return 3'd3;
        if (m < 68) return 3'd4;
        if (m < 80) return 3'd5;
        if (m < 84) return 3'd6;
        return 3'd7;
    endfunction

    function automatic logic exp_pulse(input int n);
        int m;
        m = n % 96;
        if (n == 0) return 1'b0;
        return (m == 0) || (m == 20) || (m == 32) || (m == 36) || (m == 48) ||
               (m == 68) || (m == 80) || (m == 84);
    endfunction

    task automatic apply_reset(input logic a, input logic b);
        reset = 1'b1;
        ta    = a;
        tb    = b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ta    = 1'b1;
        tb    = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s !== 3'd0 || state_change !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: s=%0d sc=%b, want s=0 sc=0", n, s, state_change);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        ta    = 1'b0;
    endtask

    task automatic test_nominal;
        int pulses;
        pulses = 0;
        apply_reset(1'b0, 1'b0);
        checks++;
        if (s !== 3'd0 || state_change !== 1'b0) begin
            errors++;
            $display("FAIL nominal_start: s=%0d sc=%b, want s=0 sc=0", s, state_change);
        end
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n <= 96 && state_change === 1'b1) pulses++;
            checks++;
            if (s !== exp_phase(n) || state_change !== exp_pulse(n)) begin
                errors++;
                $display("FAIL nominal cycle %0d: s=%0d sc=%b, want s=%0d sc=%b",
                         n, s, state_change, exp_phase(n), exp_pulse(n));
            end
        end
        checks++;
        if (pulses !== 8) begin
            errors++;
            $display("FAIL nominal_pulse_count: got %0d, want 8", pulses);
        end
    endtask

    task automatic test_ta_hold;
        logic [2:0] want;
        apply_reset(1'b1, 1'b0);
        for (int n = 1; n <= 71; n++) begin
            @(posedge clk);
            #1;
            want = (n < 56) ? 3'd0 : (n < 68) ? 3'd1 : 3'd2;
            checks++;
            if (s !== want) begin
                errors++;
                $display("FAIL ta_hold cycle %0d: s=%0d, want %0d", n, s, want);
            end
            if (n == 50) ta = 1'b0;
            if (n == 60) ta = 1'b1;
        end
        ta = 1'b0;
    endtask

    task automatic test_tb_park;
        logic [2:0] want;
        apply_reset(1'b0, 1'b1);
        for (int n = 1; n <= 160; n++) begin
            @(posedge clk);
            #1;
            if (n < 48)       want = exp_phase(n);
            else if (n < 156) want = 3'd4;
            else              want = 3'd5;
            checks++;
            if (s !== want) begin
                errors++;
                $display("FAIL tb_park cycle %0d: s=%0d, want %0d", n, s, want);
            end
            if (n == 150) tb = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        apply_reset(1'b0, 1'b0);
        repeat (70) @(posedge clk);
        #1;
        checks++;
        if (s !== 3'd5) begin
            errors++;
            $display("FAIL async_pre cycle 70: s=%0d, want 5", s);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (s !== 3'd0 || state_change !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: s=%0d sc=%b, want s=0 sc=0", s, state_change);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s !== exp_phase(n) || state_change !== exp_pulse(n)) begin
                errors++;
                $display("FAIL async_rerun cycle %0d: s=%0d sc=%b, want s=%0d sc=%b",
                         n, s, state_change, exp_phase(n), exp_pulse(n));
            end
        end
    endtask

    task automatic test_glitch;
        apply_reset(1'b0, 1'b0);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s !== exp_phase(n)) begin
                errors++;
                $display("FAIL glitch cycle %0d: s=%0d, want %0d", n, s, exp_phase(n));
            end
            ta = (n == 5) || (n == 25);
        end
        ta = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ta     = 1'b0;
        tb     = 1'b0;
        test_reset();
        test_nominal();
        test_ta_hold();
        test_tb_park();
        test_async_reset();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
